// File: rtl/rv32_ctrl_pkg.sv
// ============================================================================
// Module      : rv32_ctrl_pkg
// Description : Shared encodings for the RV32I multi-cycle control sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32_ctrl_pkg;

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        CLS_NONE   = 4'd0,
        CLS_OP     = 4'd1,
        CLS_OPIMM  = 4'd2,
        CLS_LOAD   = 4'd3,
        CLS_STORE  = 4'd4,
        CLS_BRANCH = 4'd5,
        CLS_JAL    = 4'd6,
        CLS_JALR   = 4'd7,
        CLS_LUI    = 4'd8,
        CLS_AUIPC  = 4'd9,
        CLS_FENCE  = 4'd10,
        CLS_SYSTEM = 4'd11
    } class_e;

    localparam logic [1:0] c_PC_SRC_PLUS4  = 2'd0;
    localparam logic [1:0] c_PC_SRC_TARGET = 2'd1;
    localparam logic [1:0] c_PC_SRC_JALR   = 2'd2;

    localparam logic [1:0] c_ALU_A_RS1  = 2'd0;
    localparam logic [1:0] c_ALU_A_PC   = 2'd1;
    localparam logic [1:0] c_ALU_A_ZERO = 2'd2;

    localparam logic [1:0] c_WB_ALU = 2'd0;
    localparam logic [1:0] c_WB_MDR = 2'd1;
    localparam logic [1:0] c_WB_PC4 = 2'd2;

    localparam logic [1:0] c_TRAP_NONE    = 2'd0;
    localparam logic [1:0] c_TRAP_ILLEGAL = 2'd1;
    localparam logic [1:0] c_TRAP_BUS     = 2'd2;
    localparam logic [1:0] c_TRAP_ENV     = 2'd3;

    function automatic class_e decode_class(input logic [6:0] opc);
        class_e cls;
        case (opc)
            c_OPC_OP:     cls = CLS_OP;
            c_OPC_OPIMM:  cls = CLS_OPIMM;
            c_OPC_LOAD:   cls = CLS_LOAD;
            c_OPC_STORE:  cls = CLS_STORE;
            c_OPC_BRANCH: cls = CLS_BRANCH;
            c_OPC_JAL:    cls = CLS_JAL;
            c_OPC_JALR:   cls = CLS_JALR;
            c_OPC_LUI:    cls = CLS_LUI;
            c_OPC_AUIPC:  cls = CLS_AUIPC;
            c_OPC_FENCE:  cls = CLS_FENCE;
            c_OPC_SYSTEM: cls = CLS_SYSTEM;
            default:      cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// ============================================================================
// Module      : mem_wait_timer
// Description : Wait-cycle counter shared by instruction and data requests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TMR_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic timeout_o
);

    localparam logic [TMR_W-1:0] c_LIMIT = TMR_W'(MEM_TIMEOUT);
    localparam logic [TMR_W-1:0] c_ONE   = TMR_W'(1);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + c_ONE;
        end
    end

    // Fires in the wait cycle whose increment reaches the limit, so the FSM
    // can trap on that same edge; a ready in that cycle clears instead.
    assign timeout_o = inc_i && !clr_i && (cnt_d == c_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_sequencer.sv
// ============================================================================
// Module      : multicycle_sequencer
// Description : RV32I multi-cycle control FSM (fetch/decode/exec/mem/wb/trap).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_sequencer
    import rv32_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TMR_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct12_0,
    input  logic       branch_cond,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [1:0] alu_a_sel,
    output logic       alu_b_imm,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       retire,
    output logic       halted,
    output logic [1:0] trap_cause,
    output logic [2:0] state_o
);

    state_e     state_q, state_d;
    class_e     class_q, class_d;
    class_e     w_dec_class;
    logic [1:0] trap_q, trap_d;
    logic       w_wait;
    logic       w_timeout;
    logic       w_unused_ebreak;

    // ECALL and EBREAK halt identically, so bit 20 does not steer anything.
    assign w_unused_ebreak = funct12_0;

    assign w_dec_class = decode_class(opcode);
    assign w_wait = ((state_q == ST_FETCH) && !imem_ready)
                 || ((state_q == ST_MEM)   && !dmem_ready);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMR_W       (TMR_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (!w_wait),
        .inc_i     (w_wait),
        .timeout_o (w_timeout)
    );

    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        trap_d    = trap_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_write  = 1'b0;
        mdr_write = 1'b0;
        pc_write  = 1'b0;
        pc_src    = c_PC_SRC_PLUS4;
        alu_a_sel = c_ALU_A_RS1;
        alu_b_imm = 1'b0;
        reg_write = 1'b0;
        wb_sel    = c_WB_ALU;
        retire    = 1'b0;
        halted    = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (w_timeout) begin
                    trap_d  = c_TRAP_BUS;
                    state_d = ST_TRAP;
                end
            end

            ST_DECODE: begin
                class_d = w_dec_class;
                if (w_dec_class == CLS_NONE) begin
                    trap_d  = c_TRAP_ILLEGAL;
                    state_d = ST_TRAP;
                end else if (w_dec_class == CLS_SYSTEM) begin
                    trap_d  = (funct3 == 3'b000) ? c_TRAP_ENV : c_TRAP_ILLEGAL;
                    state_d = ST_TRAP;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                alu_b_imm = (class_q != CLS_OP) && (class_q != CLS_BRANCH);
                if (class_q == CLS_AUIPC) begin
                    alu_a_sel = c_ALU_A_PC;
                end else if (class_q == CLS_LUI) begin
                    alu_a_sel = c_ALU_A_ZERO;
                end
                case (class_q)
                    CLS_BRANCH: begin
                        pc_write = 1'b1;
                        pc_src   = branch_cond ? c_PC_SRC_TARGET : c_PC_SRC_PLUS4;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    CLS_JAL, CLS_JALR: begin
                        // rd takes the old PC+4 on the same edge the PC moves.
                        reg_write = 1'b1;
                        wb_sel    = c_WB_PC4;
                        pc_write  = 1'b1;
                        pc_src    = (class_q == CLS_JAL) ? c_PC_SRC_TARGET : c_PC_SRC_JALR;
                        retire    = 1'b1;
                        state_d   = ST_FETCH;
                    end
                    CLS_FENCE: begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        state_d = ST_MEM;
                    end
                    CLS_OP, CLS_OPIMM, CLS_LUI, CLS_AUIPC: begin
                        state_d = ST_WB;
                    end
                    default: begin
                        trap_d  = c_TRAP_ILLEGAL;
                        state_d = ST_TRAP;
                    end
                endcase
            end

            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (class_q == CLS_STORE);
                if (dmem_ready) begin
                    if (class_q == CLS_LOAD) begin
                        mdr_write = 1'b1;
                        state_d   = ST_WB;
                    end else begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                end else if (w_timeout) begin
                    trap_d  = c_TRAP_BUS;
                    state_d = ST_TRAP;
                end
            end

            ST_WB: begin
                reg_write = 1'b1;
                wb_sel    = (class_q == CLS_LOAD) ? c_WB_MDR : c_WB_ALU;
                pc_write  = 1'b1;
                retire    = 1'b1;
                state_d   = ST_FETCH;
            end

            ST_TRAP: begin
                halted = 1'b1;
            end

            default: begin
                trap_d  = c_TRAP_ILLEGAL;
                state_d = ST_TRAP;
            end
        endcase
    end

    assign trap_cause = trap_q;
    assign state_o    = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            class_q <= CLS_NONE;
            trap_q  <= c_TRAP_NONE;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            trap_q  <= trap_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
// ============================================================================
// Module      : tb_multicycle_sequencer
// Description : Self-checking bench for multicycle_sequencer with a
//               per-instruction cycle-trace reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_sequencer;

    localparam int MEM_TIMEOUT = 15;

    localparam int S_BOOT = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3;
    localparam int S_MEM = 4, S_WB = 5, S_TRAP = 6;

    localparam int K_ILL = 0, K_OP = 1, K_OPIMM = 2, K_LOAD = 3, K_STORE = 4;
    localparam int K_BR = 5, K_JAL = 6, K_JALR = 7, K_LUI = 8, K_AUIPC = 9;
    localparam int K_FENCE = 10, K_SYS = 11;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_write;
        logic       mdr_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] alu_a_sel;
        logic       alu_b_imm;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       retire;
        logic       halted;
        logic [1:0] trap_cause;
        logic [2:0] st;
    } ov_t;

    typedef struct {
        ov_t  v;
        logic ir;
        logic dr;
    } cyc_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct12_0;
    logic       branch_cond;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_req, dmem_req, dmem_we, ir_write, mdr_write, pc_write;
    logic [1:0] pc_src, alu_a_sel, wb_sel, trap_cause;
    logic       alu_b_imm, reg_write, retire, halted;
    logic [2:0] state_o;
    ov_t        obs;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_sequencer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMR_W       (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct12_0   (funct12_0),
        .branch_cond (branch_cond),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .imem_req    (imem_req),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .ir_write    (ir_write),
        .mdr_write   (mdr_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .alu_a_sel   (alu_a_sel),
        .alu_b_imm   (alu_b_imm),
        .reg_write   (reg_write),
        .wb_sel      (wb_sel),
        .retire      (retire),
        .halted      (halted),
        .trap_cause  (trap_cause),
        .state_o     (state_o)
    );

    assign obs = {imem_req, dmem_req, dmem_we, ir_write, mdr_write, pc_write,
                  pc_src, alu_a_sel, alu_b_imm, reg_write, wb_sel, retire,
                  halted, trap_cause, state_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        if (o !== e) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    function automatic int class_of(input logic [6:0] opc);
        case (opc)
            7'b0110011: return K_OP;
            7'b0010011: return K_OPIMM;
            7'b0000011: return K_LOAD;
            7'b0100011: return K_STORE;
            7'b1100011: return K_BR;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            7'b0001111: return K_FENCE;
            7'b1110011: return K_SYS;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic ov_t blank(input int st);
        ov_t e;
        e = '0;
        e.st = 3'(st);
        return e;
    endfunction

    // Builds the expected cycle-by-cycle trace of one instruction, then drives
    // the readies from that trace and compares every cycle. stop_after > 0
    // abandons the instruction early (used to interrupt it with a reset).
    task automatic run_instr(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                             input logic f12, input logic bc, input int iwait,
                             input int dwait, input int stop_after, output bit trapped);
        cyc_t q[$];
        cyc_t c;
        ov_t  e;
        int   cls;
        int   tc;
        int   k;
        bit   done;
        trapped = 1'b0;
        tc = 0;
        cls = class_of(opc);

        done = 1'b0;
        k = 0;
        while (!done) begin
            k++;
            e = blank(S_FETCH);
            e.imem_req = 1'b1;
            c.dr = 1'($urandom);
            if (k > iwait) begin
                e.ir_write = 1'b1;
                c.v = e; c.ir = 1'b1; q.push_back(c);
                done = 1'b1;
            end else begin
                c.v = e; c.ir = 1'b0; q.push_back(c);
                if (k >= MEM_TIMEOUT) begin
                    trapped = 1'b1; tc = 2; done = 1'b1;
                end
            end
        end

        if (!trapped) begin
            c.v = blank(S_DECODE); c.ir = 1'($urandom); c.dr = 1'($urandom);
            q.push_back(c);
            if (cls == K_ILL) begin
                trapped = 1'b1; tc = 1;
            end else if (cls == K_SYS) begin
                trapped = 1'b1; tc = (f3 == 3'b000) ? 3 : 1;
            end
        end

        if (!trapped) begin
            e = blank(S_EXEC);
            e.alu_b_imm = (cls != K_OP) && (cls != K_BR);
            e.alu_a_sel = (cls == K_AUIPC) ? 2'd1 : (cls == K_LUI) ? 2'd2 : 2'd0;
            if (cls == K_BR) begin
                e.pc_write = 1'b1; e.pc_src = bc ? 2'd1 : 2'd0; e.retire = 1'b1;
            end else if (cls == K_JAL || cls == K_JALR) begin
                e.reg_write = 1'b1; e.wb_sel = 2'd2; e.pc_write = 1'b1;
                e.pc_src = (cls == K_JAL) ? 2'd1 : 2'd2; e.retire = 1'b1;
            end else if (cls == K_FENCE) begin
                e.pc_write = 1'b1; e.retire = 1'b1;
            end
            c.v = e; c.ir = 1'($urandom); c.dr = 1'($urandom);
            q.push_back(c);

            if (cls == K_LOAD || cls == K_STORE) begin
                done = 1'b0;
                k = 0;
                while (!done) begin
                    k++;
                    e = blank(S_MEM);
                    e.dmem_req = 1'b1;
                    e.dmem_we = (cls == K_STORE);
                    c.ir = 1'($urandom);
                    if (k > dwait) begin
                        if (cls == K_LOAD) begin
                            e.mdr_write = 1'b1;
                        end else begin
                            e.pc_write = 1'b1; e.retire = 1'b1;
                        end
                        c.v = e; c.dr = 1'b1; q.push_back(c);
                        done = 1'b1;
                    end else begin
                        c.v = e; c.dr = 1'b0; q.push_back(c);
                        if (k >= MEM_TIMEOUT) begin
                            trapped = 1'b1; tc = 2; done = 1'b1;
                        end
                    end
                end
            end

            if (!trapped && cls != K_BR && cls != K_JAL && cls != K_JALR &&
                cls != K_FENCE && cls != K_STORE) begin
                e = blank(S_WB);
                e.reg_write = 1'b1; e.wb_sel = (cls == K_LOAD) ? 2'd1 : 2'd0;
                e.pc_write = 1'b1; e.retire = 1'b1;
                c.v = e; c.ir = 1'($urandom); c.dr = 1'($urandom);
                q.push_back(c);
            end
        end

        if (trapped) begin
            for (int t = 0; t < 3; t++) begin
                e = blank(S_TRAP);
                e.halted = 1'b1;
                e.trap_cause = 2'(tc);
                c.v = e; c.ir = 1'($urandom); c.dr = 1'($urandom);
                q.push_back(c);
            end
        end

        opcode = opc; funct3 = f3; funct12_0 = f12; branch_cond = bc;
        foreach (q[i]) begin
            if (stop_after > 0 && i >= stop_after) break;
            #1;
            imem_ready = q[i].ir;
            dmem_ready = q[i].dr;
            @(negedge clk);
            check_eq($sformatf("%s_c%0d", tag, i), 32'(obs), 32'(q[i].v));
            @(posedge clk);
        end
    endtask

    // Entered just after a rising edge; leaves just after the edge into FETCH.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_eq({tag, "_async"}, 32'(obs), 32'd0);
        @(negedge clk);
        check_eq({tag, "_hold"}, 32'(obs), 32'd0);
        #1 rst_n = 1'b1;
        #1 check_eq({tag, "_boot"}, 32'(obs), 32'd0);
        @(posedge clk);
    endtask

    logic [6:0] legal_ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                   7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                   7'b0010111, 7'b0001111, 7'b1110011};

    function automatic int rnd_wait();
        if ($urandom_range(0, 9) == 0) return 14 + $urandom_range(0, 1);
        return $urandom_range(0, 2);
    endfunction

    initial begin
        bit         tr;
        logic [6:0] opc;
        logic [2:0] f3;
        int         sel;

        rst_n = 1'b1; opcode = '0; funct3 = '0; funct12_0 = 1'b0;
        branch_cond = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2 check_eq("reset_state", 32'(obs), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1 check_eq("boot_state", 32'(obs), 32'd0);
        @(posedge clk);

        run_instr("add",      7'b0110011, 3'd0, 1'b0, 1'b0, 0, 0, 0, tr);
        run_instr("lw_d3",    7'b0000011, 3'd2, 1'b0, 1'b0, 0, 3, 0, tr);
        run_instr("beq_t",    7'b1100011, 3'd0, 1'b0, 1'b1, 0, 0, 0, tr);
        run_instr("beq_nt",   7'b1100011, 3'd0, 1'b0, 1'b0, 1, 0, 0, tr);
        run_instr("jalr",     7'b1100111, 3'd0, 1'b0, 1'b0, 0, 0, 0, tr);
        run_instr("jal",      7'b1101111, 3'd0, 1'b0, 1'b0, 2, 0, 0, tr);
        run_instr("sw",       7'b0100011, 3'd2, 1'b0, 1'b0, 0, 1, 0, tr);
        run_instr("lui",      7'b0110111, 3'd0, 1'b0, 1'b0, 0, 0, 0, tr);
        run_instr("auipc",    7'b0010111, 3'd0, 1'b0, 1'b0, 0, 0, 0, tr);
        run_instr("fetch_14", 7'b0010011, 3'd0, 1'b0, 1'b0, 14, 0, 0, tr);
        run_instr("ld_14",    7'b0000011, 3'd0, 1'b0, 1'b0, 0, 14, 0, tr);
        run_instr("fetch_to", 7'b0110011, 3'd0, 1'b0, 1'b0, 255, 0, 0, tr);
        do_reset("rst_to");
        run_instr("dmem_to",  7'b0100011, 3'd0, 1'b0, 1'b0, 0, 255, 0, tr);
        do_reset("rst_dto");
        run_instr("illegal",  7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0, 0, tr);
        do_reset("rst_ill");
        run_instr("ecall",    7'b1110011, 3'd0, 1'b0, 1'b0, 0, 0, 0, tr);
        do_reset("rst_ecall");
        run_instr("ebreak",   7'b1110011, 3'd0, 1'b1, 1'b0, 0, 0, 0, tr);
        do_reset("rst_ebreak");
        run_instr("csrrw",    7'b1110011, 3'd1, 1'b0, 1'b0, 0, 0, 0, tr);
        do_reset("rst_csr");

        run_instr("lw_cut",   7'b0000011, 3'd2, 1'b0, 1'b0, 0, 5, 5, tr);
        #1 check_eq("mem_before_rst", {31'd0, dmem_req}, 32'd1);
        do_reset("rst_mem");
        run_instr("after_rst", 7'b0110011, 3'd0, 1'b0, 1'b0, 0, 0, 0, tr);

        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 13);
            f3 = 3'($urandom);
            if (sel <= 10)      opc = legal_ops[sel];
            else if (sel == 11) opc = 7'b1111111;
            else if (sel == 12) opc = 7'($urandom);
            else begin
                opc = 7'b1110011;
                f3 = ($urandom_range(0, 1) == 0) ? 3'd0 : f3;
            end
            run_instr($sformatf("rnd%0d", n), opc, f3, 1'($urandom), 1'($urandom),
                      rnd_wait(), rnd_wait(), 0, tr);
            if (tr) do_reset($sformatf("rnd%0d_rst", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Multi-cycle control FSM for the RV32I core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback. It drives the PC, IR, register-file and memory strobes, and handles ready/req handshakes with the instruction and data memories. Faults (illegal opcode, memory timeout, ECALL/EBREAK) stop the core in a sticky halt state until reset.

Parameters:
MEM_TIMEOUT, 15, max cycles a memory request may wait for ready before a bus-timeout trap (range 1..255).
TMR_W, 8, width of the wait counter; must satisfy 2^TMR_W > MEM_TIMEOUT.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
opcode  in  7  opcode field from the IR (valid from DECODE onward)
funct3  in  3  funct3 field from the IR
funct12_0  in  1  IR bit 20; selects ECALL (0) or EBREAK (1)
branch_cond  in  1  ALU compare result for the current branch
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write enable (stores)
ir_write  out  1  latch the IR from the fetch bus
mdr_write  out  1  latch load data into the MDR
pc_write  out  1  update PC at the next edge
pc_src  out  2  0=PC+4, 1=PC+imm, 2=(rs1+imm)&~1
alu_a_sel  out  2  0=rs1, 1=PC, 2=zero
alu_b_imm  out  1  ALU operand B: 1=immediate, 0=rs2
reg_write  out  1  register file write enable
wb_sel  out  2  0=ALU, 1=MDR, 2=PC+4
retire  out  1  one-cycle pulse when an instruction completes
halted  out  1  sticky; high in TRAP
trap_cause  out  2  0=none, 1=illegal, 2=bus timeout, 3=ECALL/EBREAK
state_o  out  3  current state, for debug

Behaviour:
- Reset and outputs:
  - Reset (async) sets state to BOOT, the wait counter to 0, the class register to NONE and trap_cause to 0.
  - Every output is 0 in BOOT.
  - Outputs are a combinational decode of the registered state and the registered instruction class. No output depends on imem_ready or dmem_ready except the strobes listed below.
- BOOT (0): go to FETCH on the first edge after rst_n goes high.
- FETCH (1):
  - imem_req is held high. The counter increments each cycle that imem_ready is low.
  - If imem_ready is high: ir_write=1, counter clears, go to DECODE.
  - If the counter reaches MEM_TIMEOUT with imem_ready still low: trap_cause=2, go to TRAP.
- DECODE (2): register the class from opcode.
  - Classes: OP 0110011, OPIMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, FENCE 0001111, SYSTEM 1110011.
  - Any other opcode: trap_cause=1, go to TRAP.
  - SYSTEM with funct3=0: trap_cause=3, go to TRAP.
  - SYSTEM with funct3≠0: trap_cause=1, go to TRAP.
  - Every other class: go to EXEC.
- EXEC (3):
  - alu_b_imm=1 for every class except OP and BRANCH.
  - alu_a_sel=1 for AUIPC, 2 for LUI, otherwise 0.
  - BRANCH: pc_write=1, pc_src = branch_cond ? 1 : 0, retire=1, go to FETCH.
  - JAL / JALR: reg_write=1, wb_sel=2, pc_write=1, pc_src=1 (JAL) or 2 (JALR), retire=1, go to FETCH. rd receives the old PC+4; the PC and rd update on the same edge.
  - FENCE: pc_write=1, pc_src=0, retire=1, go to FETCH.
  - LOAD / STORE: go to MEM.
  - OP / OPIMM / LUI / AUIPC: go to WB.
- MEM (4):
  - dmem_req is held high; dmem_we = (class==STORE). The counter works as in FETCH.
  - On dmem_ready, LOAD: mdr_write=1, go to WB.
  - On dmem_ready, STORE: pc_write=1, pc_src=0, retire=1, go to FETCH.
  - On timeout: trap_cause=2, go to TRAP.
- WB (5): reg_write=1, wb_sel = (LOAD ? 1 : 0), pc_write=1, pc_src=0, retire=1, go to FETCH.
- TRAP (6):
  - halted=1; all other strobes 0; trap_cause held.
  - Exit only by reset.
- Latency with zero-wait memory (ready in the first request cycle):
  - Branch, jump, FENCE: 3 cycles.
  - ALU ops, STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1.
- Boundary conditions:
  - ready arriving in the same cycle the counter hits MEM_TIMEOUT: ready wins, no trap.
  - ready while not requesting: ignored.
  - Reset asserted mid-MEM: dmem_req drops immediately (async); a partial access is the memory's responsibility.
  - Unused state encoding 7: go to TRAP with trap_cause=1.

Decomposition:
- Shared package rv32_ctrl_pkg holds:
  - opcode localparams;
  - state encoding;
  - class encoding;
  - pc_src, alu_a_sel, wb_sel and trap_cause codes.
- One sub-module, mem_wait_timer: counter with clr/inc inputs and a timeout output at MEM_TIMEOUT. It is shared by the FETCH and MEM states.

Test Plan:
- ADD (0110011), zero-wait memory -> states FETCH, DECODE, EXEC, WB; reg_write=1 with wb_sel=0 in WB; retire pulse exactly 4 cycles after the first imem_req.
- LW with dmem_ready delayed 3 cycles -> dmem_req high for 4 cycles, dmem_we=0, mdr_write one cycle, WB wb_sel=1, retire at cycle 8.
- BEQ with branch_cond=1, then with branch_cond=0 -> pc_src=1 vs pc_src=0; pc_write=1 and retire=1 in EXEC; no reg_write.
- JALR -> EXEC shows reg_write=1, wb_sel=2, pc_src=2, pc_write=1 in one cycle.
- imem_ready held 0 with MEM_TIMEOUT=15 -> TRAP after 15 wait cycles, trap_cause=2, halted=1 until rst_n pulses; ready on the 15th wait cycle gives no trap.
- Opcode 1111111 -> trap_cause=1. ECALL -> trap_cause=3. rst_n low mid-MEM -> all outputs 0 asynchronously; BOOT then FETCH after release.
